// File: rtl/tl_ul_scratch_responder_if.sv
// TileLink-UL A/D channel bundle between an initiator (master) and the scratch responder (slave).
interface tl_ul_scratch_responder_if #(
   parameter int ADDR_W = 12,
   parameter int SRC_W  = 4
);
   logic              a_valid;
   logic              a_ready;
   logic [2:0]        a_opcode;
   logic [2:0]        a_size;
   logic [SRC_W-1:0]  a_source;
   logic [ADDR_W-1:0] a_address;
   logic [3:0]        a_mask;
   logic [31:0]       a_data;
   logic              d_valid;
   logic              d_ready;
   logic [2:0]        d_opcode;
   logic [2:0]        d_size;
   logic [SRC_W-1:0]  d_source;
   logic              d_denied;
   logic [31:0]       d_data;

   modport master (
      output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
      input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
   );

   modport slave (
      input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
      output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
   );
endinterface

// File: rtl/tl_ul_scratch_responder.sv
// TileLink-UL scratch-array responder: access commits at A fire, response on D next cycle via a 2-entry queue.
// a_ready drops only when the queue is full and d_ready is low; TL_SCRATCH_RESP_ASSERT_EN adds simulation checks.
module tl_ul_scratch_responder #(
   parameter int ADDR_W = 12,
   parameter int SRC_W  = 4,
   parameter int DEPTH  = 64
) (
   input logic                      clock,
   input logic                      reset_n,
   tl_ul_scratch_responder_if.slave tl
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic [2:0]       opcode;
      logic [2:0]       size;
      logic [SRC_W-1:0] source;
      logic             denied;
      logic [31:0]      data;
   } rsp_t;

   logic [31:0]      mem [DEPTH];
   rsp_t             q0, q1, rsp_new;
   logic [1:0]       count, wr_slot;
   logic             a_fire, d_fire, is_get, is_put, align_ok, legal;
   logic [3:0]       lanes;
   logic [IDX_W-1:0] word;

   assign a_fire      = tl.a_valid & tl.a_ready;
   assign d_fire      = tl.d_valid & tl.d_ready;
   assign tl.a_ready  = (count != 2'd2) | tl.d_ready;
   assign tl.d_valid  = (count != 2'd0);
   assign tl.d_opcode = q0.opcode;
   assign tl.d_size   = q0.size;
   assign tl.d_source = q0.source;
   assign tl.d_denied = q0.denied;
   assign tl.d_data   = q0.data;
   assign word        = tl.a_address[IDX_W+1:2];
   assign wr_slot     = count - {1'b0, d_fire};

   always_comb begin
      is_get = (tl.a_opcode == 3'd4);
      is_put = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1);
      case (tl.a_size)
         3'd0:    begin lanes = 4'b0001 << tl.a_address[1:0]; align_ok = 1'b1; end
         3'd1:    begin lanes = 4'b0011 << tl.a_address[1:0]; align_ok = !tl.a_address[0]; end
         default: begin lanes = 4'b1111; align_ok = (tl.a_address[1:0] == 2'b00); end
      endcase
      legal = (is_get || is_put) && (tl.a_size <= 3'd2) && align_ok
           && ({2'b00, tl.a_address[ADDR_W-1:2]} < ADDR_W'(DEPTH))
           && (is_get || ((tl.a_mask != 4'h0) && ((tl.a_mask & ~lanes) == 4'h0)));
      rsp_new.opcode = is_get ? 3'd1 : 3'd0;
      rsp_new.size   = tl.a_size;
      rsp_new.source = tl.a_source;
      rsp_new.denied = !legal;
      rsp_new.data   = (legal && is_get) ? mem[word] : 32'h0;
   end

   // Array is deliberately not reset; only lanes named in a_mask are touched.
   always_ff @(posedge clock) begin
      if (a_fire && legal && is_put) begin
         for (int i = 0; i < 4; i++) begin
            if (tl.a_mask[i]) mem[word][8*i +: 8] <= tl.a_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= 2'd0;
         q0    <= '0;
         q1    <= '0;
      end else begin
         if (d_fire) q0 <= q1;
         if (a_fire) begin
            if (wr_slot == 2'd0) q0 <= rsp_new;
            else                 q1 <= rsp_new;
         end
         count <= count + {1'b0, a_fire} - {1'b0, d_fire};
      end
   end

`ifdef TL_SCRATCH_RESP_ASSERT_EN
`ifndef SYNTHESIS
   logic                      stall_q;
   logic [ADDR_W+SRC_W+41:0]  pay, pay_q;

   assign pay = {tl.a_opcode, tl.a_size, tl.a_source, tl.a_address, tl.a_mask, tl.a_data};

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= 1'b0;
         pay_q   <= '0;
      end else begin
         if (stall_q && !tl.a_valid) begin
            $display("tl_ul_scratch_responder: a_valid dropped without A fire");
            $fatal(1, "a_valid protocol violation");
         end
         if (stall_q && tl.a_valid && (pay != pay_q)) begin
            $display("tl_ul_scratch_responder: A payload changed while stalled");
            $fatal(1, "A payload stability violation");
         end
         if (a_fire && !d_fire && (count == 2'd2)) begin
            $display("tl_ul_scratch_responder: response queue overflow");
            $fatal(1, "queue overflow");
         end
         if (d_fire && (count == 2'd0)) begin
            $display("tl_ul_scratch_responder: response queue underflow");
            $fatal(1, "queue underflow");
         end
         stall_q <= tl.a_valid & !tl.a_ready;
         pay_q   <= pay;
      end
   end
`endif
`else
   // Protocol checks compiled out; datapath is identical either way.
`endif
endmodule
